// File: rtl/leaf_user_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module   : leaf_user_fifo_bridge_fifo
// Purpose  : First-word-fall-through FIFO used by the bridge. The head entry is
//            always visible on rdata. The caller guarantees push only when not
//            full and pop only when not empty. Storage is not reset.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            push, wdata     - write strobe and word
//            pop, rdata      - read strobe and head word
//            count           - registered occupancy (0..DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
module leaf_user_fifo_bridge_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata,
  output logic [ADDR_BITS:0]   count
);

  localparam logic [ADDR_BITS-1:0] PTR_ONE = (ADDR_BITS)'(1);
  localparam logic [ADDR_BITS:0]   CNT_ONE = (ADDR_BITS+1)'(1);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;

  // Storage has no reset so it can map onto LUTRAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr];

  // Pointers are ADDR_BITS wide and wrap naturally because DEPTH is a power
  // of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (!push && pop) begin
        count <= count - CNT_ONE;
      end
    end
  end

endmodule

// ============================================================================
// Module   : leaf_user_fifo_bridge
// Purpose  : Kernel-side endpoint of the leaf interface user port. Buffers one
//            interface-to-user stream and one user-to-interface stream through
//            FWFT FIFOs and exposes ap_fifo-style ports to the HLS kernel.
// Ports    : clk_user, reset_n                 - clock, async active-low reset
//            dout_leaf_interface2user,
//            vld_interface2user,
//            ack_user2interface                - inbound leaf handshake
//            din_leaf_user2interface,
//            vld_user2interface,
//            ack_interface2user                - outbound leaf handshake
//            in_dout, in_empty_n, in_read      - kernel input FIFO port
//            out_din, out_full_n, out_write    - kernel output FIFO port
//            in_count, out_count               - FIFO occupancies
//            err_underflow, err_overflow       - sticky illegal-access flags
// Revision : 1.0 - initial release
// ============================================================================
module leaf_user_fifo_bridge #(
  parameter int PAYLOAD_BITS = 32,
  parameter int DEPTH        = 16,
  parameter int ADDR_BITS    = 4
) (
  input  logic                    clk_user,
  input  logic                    reset_n,
  input  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user,
  input  logic                    vld_interface2user,
  output logic                    ack_user2interface,
  output logic [PAYLOAD_BITS-1:0] din_leaf_user2interface,
  output logic                    vld_user2interface,
  input  logic                    ack_interface2user,
  output logic [PAYLOAD_BITS-1:0] in_dout,
  output logic                    in_empty_n,
  input  logic                    in_read,
  input  logic [PAYLOAD_BITS-1:0] out_din,
  output logic                    out_full_n,
  input  logic                    out_write,
  output logic [ADDR_BITS:0]      in_count,
  output logic [ADDR_BITS:0]      out_count,
  output logic                    err_underflow,
  output logic                    err_overflow
);

  localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS+1)'(DEPTH);

  logic reset_n_meta;
  logic reset_n_sync;
  logic in_push;
  logic in_pop;
  logic out_push;
  logic out_pop;

  // Reset release is synchronised so the leaf interface never sees ack rise
  // on a metastable edge; assertion stays asynchronous.
  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      reset_n_meta <= 1'b0;
      reset_n_sync <= 1'b0;
    end else begin
      reset_n_meta <= 1'b1;
      reset_n_sync <= reset_n_meta;
    end
  end

  // ack is built only from registered state, so a full FIFO cannot accept a
  // word in the same cycle that the kernel pops one.
  assign ack_user2interface = reset_n_sync && (in_count != FULL_COUNT);
  assign in_empty_n         = (in_count != '0);
  assign in_push            = vld_interface2user && ack_user2interface;
  assign in_pop             = in_read && in_empty_n;

  assign out_full_n         = (out_count != FULL_COUNT);
  assign vld_user2interface = (out_count != '0);
  assign out_push           = out_write && out_full_n;
  assign out_pop            = vld_user2interface && ack_interface2user;

  leaf_user_fifo_bridge_fifo #(
    .WIDTH     (PAYLOAD_BITS),
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_in_fifo (
    .clk   (clk_user),
    .rst_n (reset_n),
    .push  (in_push),
    .pop   (in_pop),
    .wdata (dout_leaf_interface2user),
    .rdata (in_dout),
    .count (in_count)
  );

  leaf_user_fifo_bridge_fifo #(
    .WIDTH     (PAYLOAD_BITS),
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_out_fifo (
    .clk   (clk_user),
    .rst_n (reset_n),
    .push  (out_push),
    .pop   (out_pop),
    .wdata (out_din),
    .rdata (din_leaf_user2interface),
    .count (out_count)
  );

  // Sticky error flags; only reset clears them.
  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      if (in_read && !in_empty_n) begin
        err_underflow <= 1'b1;
      end
      if (out_write && !out_full_n) begin
        err_overflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_leaf_user_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_leaf_user_fifo_bridge
// Purpose  : Self-checking bench for leaf_user_fifo_bridge. A queue-based
//            reference model predicts handshakes, counts, flags and data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_leaf_user_fifo_bridge;

  localparam int W = 32;
  localparam int D = 16;

  logic          clk_user = 1'b0;
  logic          reset_n;
  logic [W-1:0]  dout_leaf_interface2user;
  logic          vld_interface2user;
  logic          ack_user2interface;
  logic [W-1:0]  din_leaf_user2interface;
  logic          vld_user2interface;
  logic          ack_interface2user;
  logic [W-1:0]  in_dout;
  logic          in_empty_n;
  logic          in_read;
  logic [W-1:0]  out_din;
  logic          out_full_n;
  logic          out_write;
  logic [4:0]    in_count;
  logic [4:0]    out_count;
  logic          err_underflow;
  logic          err_overflow;

  always #5 clk_user = ~clk_user;

  leaf_user_fifo_bridge #(
    .PAYLOAD_BITS (W),
    .DEPTH        (D),
    .ADDR_BITS    (4)
  ) dut (
    .clk_user                 (clk_user),
    .reset_n                  (reset_n),
    .dout_leaf_interface2user (dout_leaf_interface2user),
    .vld_interface2user       (vld_interface2user),
    .ack_user2interface       (ack_user2interface),
    .din_leaf_user2interface  (din_leaf_user2interface),
    .vld_user2interface       (vld_user2interface),
    .ack_interface2user       (ack_interface2user),
    .in_dout                  (in_dout),
    .in_empty_n               (in_empty_n),
    .in_read                  (in_read),
    .out_din                  (out_din),
    .out_full_n               (out_full_n),
    .out_write                (out_write),
    .in_count                 (in_count),
    .out_count                (out_count),
    .err_underflow            (err_underflow),
    .err_overflow             (err_overflow)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [W-1:0] q_in[$];
  logic [W-1:0] q_out[$];
  int  edges_since_release = 0;
  bit  m_err_u = 1'b0;
  bit  m_err_o = 1'b0;
  int  in_pushes = 0;
  int  out_pushes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Monitor / scoreboard: samples on the falling edge, compares the DUT to the
  // model, then applies the transfers the model predicts for the next edge.
  always @(negedge clk_user) begin : monitor
    bit ack_e;
    bit in_wr;
    bit in_rd;
    bit out_wr;
    bit out_rd;
    if (!reset_n) begin
      check("rst_ack",        64'(ack_user2interface), 64'(0));
      check("rst_in_empty_n", 64'(in_empty_n),         64'(0));
      check("rst_vld_out",    64'(vld_user2interface), 64'(0));
      check("rst_out_full_n", 64'(out_full_n),         64'(1));
      check("rst_in_count",   64'(in_count),           64'(0));
      check("rst_out_count",  64'(out_count),          64'(0));
      check("rst_err_u",      64'(err_underflow),      64'(0));
      check("rst_err_o",      64'(err_overflow),       64'(0));
      q_in.delete();
      q_out.delete();
      m_err_u = 1'b0;
      m_err_o = 1'b0;
      edges_since_release = 0;
    end else begin
      ack_e = (edges_since_release >= 2) && (q_in.size() < D);
      check("ack_user2interface", 64'(ack_user2interface), 64'(ack_e));
      check("in_empty_n",         64'(in_empty_n),         64'(q_in.size() != 0));
      check("in_count",           64'(in_count),           64'(q_in.size()));
      check("out_count",          64'(out_count),          64'(q_out.size()));
      check("vld_user2interface", 64'(vld_user2interface), 64'(q_out.size() != 0));
      check("out_full_n",         64'(out_full_n),         64'(q_out.size() != D));
      check("err_underflow",      64'(err_underflow),      64'(m_err_u));
      check("err_overflow",       64'(err_overflow),       64'(m_err_o));
      if (q_in.size() != 0) begin
        check("in_dout", 64'(in_dout), 64'(q_in[0]));
      end
      if (q_out.size() != 0) begin
        check("din_leaf_user2interface", 64'(din_leaf_user2interface), 64'(q_out[0]));
      end

      in_wr  = vld_interface2user && ack_e;
      in_rd  = in_read && (q_in.size() != 0);
      out_wr = out_write && (q_out.size() != D);
      out_rd = (q_out.size() != 0) && ack_interface2user;
      if (in_read && q_in.size() == 0) m_err_u = 1'b1;
      if (out_write && q_out.size() == D) m_err_o = 1'b1;

      if (in_rd) void'(q_in.pop_front());
      if (in_wr) begin
        q_in.push_back(dout_leaf_interface2user);
        in_pushes++;
      end
      if (out_rd) void'(q_out.pop_front());
      if (out_wr) begin
        q_out.push_back(out_din);
        out_pushes++;
      end
      if (edges_since_release < 2) edges_since_release++;
    end
  end

  task automatic tick();
    @(posedge clk_user);
    #1;
  endtask

  task automatic idle_inputs();
    vld_interface2user       = 1'b0;
    dout_leaf_interface2user = '0;
    in_read                  = 1'b0;
    out_write                = 1'b0;
    out_din                  = '0;
    ack_interface2user       = 1'b0;
  endtask

  initial begin : stimulus
    int base;
    int base_o;
    int guard;
    reset_n = 1'b0;
    idle_inputs();

    // Reset held with random activity on every input
    repeat (5) begin
      tick();
      vld_interface2user       = 1'($urandom);
      dout_leaf_interface2user = $urandom;
      in_read                  = 1'($urandom);
      out_write                = 1'($urandom);
      out_din                  = $urandom;
      ack_interface2user       = 1'($urandom);
    end
    tick();
    idle_inputs();
    reset_n = 1'b1;
    repeat (4) tick();

    // Input fill: 16 words, then extra offered words that must be refused
    base  = in_pushes;
    guard = 0;
    vld_interface2user = 1'b1;
    while ((in_pushes - base) < D && guard < 200) begin
      dout_leaf_interface2user = 32'h1000 + 32'(in_pushes - base);
      tick();
      guard++;
    end
    if (guard >= 200) timeout("input_fill");
    dout_leaf_interface2user = 32'hDEAD_BEEF;
    repeat (3) tick();
    vld_interface2user = 1'b0;
    tick();

    // Input drain
    in_read = 1'b1;
    repeat (D) tick();
    in_read = 1'b0;
    repeat (2) tick();

    // Output backpressure then alternate acks
    ack_interface2user = 1'b0;
    for (int i = 0; i < 5; i++) begin
      out_write = 1'b1;
      out_din   = 32'hA0 + 32'(i);
      tick();
    end
    out_write = 1'b0;
    repeat (5) tick();
    for (int i = 0; i < 12; i++) begin
      ack_interface2user = (i % 2) == 1;
      tick();
    end
    ack_interface2user = 1'b0;
    repeat (2) tick();

    // Error flags: underflow, then 17 writes into a blocked output FIFO
    in_read = 1'b1;
    repeat (2) tick();
    in_read = 1'b0;
    for (int i = 0; i < 17; i++) begin
      out_write = 1'b1;
      out_din   = 32'hB00 + 32'(i);
      tick();
    end
    out_write = 1'b0;
    repeat (2) tick();
    ack_interface2user = 1'b1;
    repeat (20) tick();
    ack_interface2user = 1'b0;
    tick();

    // Random streaming, 1000+ words in each direction
    base   = in_pushes;
    base_o = out_pushes;
    guard  = 0;
    while (((in_pushes - base) < 1000 || (out_pushes - base_o) < 1000) && guard < 20000) begin
      vld_interface2user       = ($urandom % 4) != 0;
      dout_leaf_interface2user = $urandom;
      in_read                  = ($urandom % 4) != 0;
      out_write                = ($urandom % 4) != 0;
      out_din                  = $urandom;
      ack_interface2user       = ($urandom % 4) != 0;
      tick();
      guard++;
    end
    if (guard >= 20000) timeout("streaming");
    idle_inputs();
    in_read            = 1'b1;
    ack_interface2user = 1'b1;
    repeat (20) tick();
    idle_inputs();
    tick();

    // Mid-operation reset with 8 words buffered each way
    guard = 0;
    while ((q_in.size() < 8 || q_out.size() < 8) && guard < 100) begin
      vld_interface2user       = q_in.size() < 8;
      dout_leaf_interface2user = $urandom;
      out_write                = q_out.size() < 8;
      out_din                  = $urandom;
      tick();
      guard++;
    end
    if (guard >= 100) timeout("mid_reset_fill");
    idle_inputs();
    in_read = 1'b1;
    tick();
    in_read = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/leaf_user_fifo_bridge.md
# leaf_user_fifo_bridge

Kernel-side endpoint of the leaf interface's user port handshake. It terminates one interface-to-user stream and one user-to-interface stream inside the user kernel region, clocked by `clk_user`. Each direction passes through a first-word-fall-through FIFO. Toward the HLS kernel it presents ap_fifo-style ports: empty_n/read for input and full_n/write for output. A kernel with N ports instantiates one bridge per port pair.

## Interface
Parameters:
- PAYLOAD_BITS, 32, data word width; matches the leaf interface payload.
- DEPTH, 16, entries per FIFO; must be a power of two, minimum 2.
- ADDR_BITS, 4, log2(DEPTH).

Ports:
- clk_user  in  1  user clock; the only clock in the block.
- reset_n  in  1  asynchronous, active-low reset.
- dout_leaf_interface2user  in  PAYLOAD_BITS  word from the leaf interface.
- vld_interface2user  in  1  word valid from the leaf interface.
- ack_user2interface  out  1  bridge can accept a word this cycle.
- din_leaf_user2interface  out  PAYLOAD_BITS  word to the leaf interface.
- vld_user2interface  out  1  word valid to the leaf interface.
- ack_interface2user  in  1  leaf interface accepts the word this cycle.
- in_dout  out  PAYLOAD_BITS  head of the input FIFO, delivered to the kernel.
- in_empty_n  out  1  input FIFO is not empty.
- in_read  in  1  kernel pops the input head.
- out_din  in  PAYLOAD_BITS  word from the kernel.
- out_full_n  out  1  output FIFO is not full.
- out_write  in  1  kernel pushes out_din.
- in_count  out  ADDR_BITS+1  occupancy of the input FIFO.
- out_count  out  ADDR_BITS+1  occupancy of the output FIFO.
- err_underflow  out  1  sticky flag: in_read was asserted while in_empty_n=0.
- err_overflow  out  1  sticky flag: out_write was asserted while out_full_n=0.

## Operation
- Transfer rule on both interface sides: a word moves on a rising clk_user edge where vld and ack are both 1. Nothing else moves a word.
- Input FIFO:
  - Push when vld_interface2user && ack_user2interface.
  - ack_user2interface = reset_n_sync && (in_count != DEPTH). It depends only on registered state, never on vld.
  - Pop when in_read && in_empty_n. in_dout always shows the head entry; its value is don't-care when the FIFO is empty.
- Output FIFO:
  - Push when out_write && out_full_n.
  - vld_user2interface = (out_count != 0). din_leaf_user2interface always shows the head entry.
  - Pop when vld_user2interface && ack_interface2user.
  - Once asserted, vld_user2interface and its data stay stable until the word is acked.
- Each FIFO has read and write pointers of ADDR_BITS bits that wrap modulo DEPTH, plus a count of ADDR_BITS+1 bits. On a simultaneous push and pop the count is unchanged and both pointers advance.
- Illegal kernel accesses have no effect on FIFO state:
  - in_read while empty is ignored and sets err_underflow.
  - out_write while full is ignored, drops the word, and sets err_overflow.
  - Error flags clear only on reset.
- Storage is a register array or LUTRAM with no reset. Pointers, counts and flags all reset.

## Timing
- Reset (reset_n=0, asynchronous):
  - Pointers = 0; in_count = out_count = 0.
  - in_empty_n = 0, vld_user2interface = 0, out_full_n = 1.
  - ack_user2interface = 0, err_* = 0.
  - din_leaf_user2interface and in_dout are don't-care.
- Reset deassertion: ack_user2interface first rises on the second clk_user edge after reset_n rises. The path is a two-flop synchronizer named reset_n_sync.
- Reset asserted mid-transfer discards all buffered words. No word is presented after reset until a new push occurs.
- Latency from interface push to in_empty_n=1 with in_dout valid: 1 cycle. A word accepted at edge k is visible after edge k.
- Latency from kernel push to vld_user2interface=1: 1 cycle.
- Throughput: 1 word per cycle per direction, sustained, including at count = DEPTH-1 with simultaneous push and pop.
- Input FIFO full: ack_user2interface=0. A pop at edge k raises ack after edge k, so it is 1 in the following cycle. A full FIFO never accepts a push in the same cycle as a pop (no bypass).
- Output FIFO empty: out_full_n stays 1. A push and the interface ack cannot coincide on the same entry because vld is 0.
- Status timing: in_count and out_count are registered and reflect transfers completed by the previous edge. out_full_n = (out_count != DEPTH).

## Test plan
- Reset behaviour:
  - Stimulus: hold reset_n=0 and drive random inputs.
  - Required: all outputs at their reset values, and ack_user2interface rises exactly 2 edges after release.
- Input fill and drain:
  - Stimulus: push 16 words 0x1000..0x100F with in_read=0.
  - Required: ack_user2interface drops after the 16th push and in_count=16.
  - Then assert in_read continuously. Required: in_dout sequence is 0x1000..0x100F in order, ack returns 1 cycle after the first pop, and in_empty_n=0 after the last pop.
- Output backpressure:
  - Stimulus: kernel writes 0xA0..0xA4 while ack_interface2user=0 for 10 cycles.
  - Required: vld_user2interface=1 with data 0xA0 held stable throughout.
  - Then toggle ack on alternate cycles. Required: 5 words delivered in order, then vld_user2interface=0.
- Streaming wrap-around:
  - Stimulus: 1000 random words through each direction with random vld/ack/read/write.
  - Required: output order matches a scoreboard, no loss and no duplication, and pointers wrap past 15 correctly.
- Error flags:
  - Stimulus: in_read=1 while empty; later, 17 out_write pulses with ack_interface2user=0.
  - Required: err_underflow=1 and in_count stays 0; err_overflow=1, out_count=16, and the 17th word is never delivered.
- Mid-operation reset:
  - Stimulus: 8 words buffered in each FIFO, then pulse reset_n low for 1 cycle.
  - Required: counts=0, vld_user2interface=0, in_empty_n=0, and err_* cleared immediately.
